uart_boot_loader: RTL

Loads a program image into the unified instruction/data memory over a UART serial line before the core starts executing. Sits upstream of the RISC-V core: it drives the memory write port while holding the core idle, then raises `core_run` so the core fetches from the base address. It runs on the same divided clock as the core.

---
 rtl/boot_pkg.sv | 27 ++
 rtl/uart_rx.sv | 103 ++++++++++
 rtl/uart_boot_loader.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
// BOOT_CHECKSUM_EN adds the CHECK state to the loader FSM.
package boot_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned LEN_LIMIT  = 255;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
`ifdef BOOT_CHECKSUM_EN
        CHECK,
`endif
        RUN,
        ERROR
    } boot_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, false-start rejection,
// one-cycle byte_valid on a good stop bit, frame_err on a bad one.
module uart_rx
    import boot_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              byte_valid,
    output logic [BYTE_W-1:0] byte_data,
    output logic              frame_err
);

    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);

    rx_state_t         state, state_next;
    logic              rx_meta, rx_sync, rx_prev;
    logic [CW-1:0]     baud_cnt;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] shreg;
    logic              cnt_clr;
    logic              half_done, full_done;

    assign half_done = (baud_cnt == CW'(HALF - 1));
    assign full_done = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    assign byte_data = shreg;

    // Synchronize the line and keep one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receiver state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RX_IDLE;
        else        state <= state_next;
    end

    // Next state, sample strobes and result pulses
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    state_next = RX_START;
                    cnt_clr    = 1'b1;
                end
            end
            RX_START: begin
                if (half_done) begin
                    cnt_clr    = 1'b1;
                    state_next = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (full_done) begin
                    cnt_clr = 1'b1;
                    if (bit_cnt == 3'd7) state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (full_done) begin
                    state_next = RX_IDLE;
                    if (rx_sync) byte_valid = 1'b1;
                    else         frame_err  = 1'b1;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    // Baud counter, bit counter and LSB-first shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            if (cnt_clr || state == RX_IDLE) baud_cnt <= '0;
            else                             baud_cnt <= baud_cnt + CW'(1);
            if (state == RX_START) bit_cnt <= '0;
            if (state == RX_DATA && full_done) begin
                shreg   <= {rx_sync, shreg[BYTE_W-1:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a length-prefixed image and writes it word by
// word into memory, then releases the core. Define BOOT_CHECKSUM_EN to
// require a trailing XOR checksum byte before release.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned MEM_WORDS   = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        rx,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_run,
    output logic        busy,
    output logic        err
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int unsigned MAX_WORDS    = (MEM_WORDS > LEN_LIMIT) ? LEN_LIMIT : MEM_WORDS;
    localparam logic [BYTE_W-1:0] MAX_LEN   = BYTE_W'(MAX_WORDS);
    localparam int unsigned BCW          = $clog2(WORD_BYTES);
    localparam logic [BCW-1:0]    LAST_BYTE = BCW'(WORD_BYTES - 1);

    boot_state_t       state, state_next;
    logic              byte_valid, frame_err;
    logic [BYTE_W-1:0] byte_data;
    logic [BYTE_W-1:0] len;
    logic [BYTE_W-1:0] word_idx;
    logic [BCW-1:0]    byte_cnt;
    logic [23:0]       word_buf;
`ifdef BOOT_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;
`endif

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (CLK),
        .rst_n      (RST),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    // Loader state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        core_run   = 1'b0;
        busy       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                if (frame_err) state_next = ERROR;
                else if (byte_valid)
                    state_next = (byte_data == '0 || byte_data > MAX_LEN) ? ERROR : LOAD;
            end
            LOAD: begin
                busy = 1'b1;
                if (frame_err) state_next = ERROR;
                else if (byte_valid && byte_cnt == LAST_BYTE) state_next = WRITE;
            end
            WRITE: begin
                busy   = 1'b1;
                mem_we = 1'b1;
                if (frame_err) state_next = ERROR;
                else if (word_idx + 8'd1 == len)
`ifdef BOOT_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = RUN;
`endif
                else state_next = LOAD;
            end
`ifdef BOOT_CHECKSUM_EN
            CHECK: begin
                busy = 1'b1;
                if (frame_err) state_next = ERROR;
                else if (byte_valid) state_next = (byte_data == csum) ? RUN : ERROR;
            end
`endif
            RUN:     core_run = 1'b1;
            ERROR:   err      = 1'b1;
            default: state_next = ERROR;
        endcase
    end

    // Length latch, word assembly and write-port registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            len       <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            word_buf  <= '0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            if (state == IDLE && byte_valid) begin
                len      <= byte_data;
                word_idx <= '0;
                byte_cnt <= '0;
`ifdef BOOT_CHECKSUM_EN
                csum     <= '0;
`endif
            end
            if (state == LOAD && byte_valid) begin
                byte_cnt <= byte_cnt + BCW'(1);
`ifdef BOOT_CHECKSUM_EN
                csum     <= csum ^ byte_data;
`endif
                // The top byte goes straight into mem_wdata so the word is
                // ready in the WRITE cycle without an extra buffer stage.
                case (byte_cnt)
                    2'd0: word_buf[7:0]   <= byte_data;
                    2'd1: word_buf[15:8]  <= byte_data;
                    2'd2: word_buf[23:16] <= byte_data;
                    default: begin
                        mem_wdata <= {byte_data, word_buf};
                        mem_addr  <= BASE_ADDR + {22'b0, word_idx, 2'b00};
                    end
                endcase
            end
            if (state == WRITE) word_idx <= word_idx + 8'd1;
        end
    end

endmodule
